// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner: rotates one-hot column strobes, freezes on a row
// response, debounces press and release, and emits a one-cycle key event.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 8192
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] rows_i,
    output logic [3:0] cols_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       scanning_o
);
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] SETTLE   = DIV_W'(2);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

    logic [3:0]       sync_q, rows_s_q;
    logic [1:0]       state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DB_W-1:0]  db_q, db_d;
    logic [3:0]       pat_q, pat_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic [1:0]       row_lo;

    // Lowest-index responding row wins when several rows are high.
    always_comb begin
        row_lo = 2'd3;
        if (pat_q[0])      row_lo = 2'd0;
        else if (pat_q[1]) row_lo = 2'd1;
        else if (pat_q[2]) row_lo = 2'd2;
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        div_d       = div_q;
        db_d        = db_q;
        pat_d       = pat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        case (state_q)
            ST_SCAN: begin
                // Detection beats rotation so the responding column stays driven.
                if (div_q >= SETTLE && rows_s_q != 4'b0000) begin
                    pat_d   = rows_s_q;
                    db_d    = '0;
                    state_d = ST_PRESS_DB;
                end else if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_PRESS_DB: begin
                if (rows_s_q == 4'b0000) begin
                    state_d = ST_SCAN;
                    div_d   = '0;
                end else if (rows_s_q != pat_q) begin
                    pat_d = rows_s_q;
                    db_d  = '0;
                end else if (db_q == DB_LAST) begin
                    key_code_d  = {row_lo, col_idx_q};
                    key_valid_d = 1'b1;
                    state_d     = ST_HELD;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            ST_HELD: begin
                if (rows_s_q == 4'b0000) begin
                    db_d    = '0;
                    state_d = ST_REL_DB;
                end
            end
            ST_REL_DB: begin
                if (rows_s_q != 4'b0000) begin
                    db_d = '0;
                end else if (db_q == DB_LAST) begin
                    state_d   = ST_SCAN;
                    div_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= 4'b0000;
            rows_s_q    <= 4'b0000;
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            div_q       <= '0;
            db_q        <= '0;
            pat_q       <= 4'b0000;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            sync_q      <= rows_i;
            rows_s_q    <= sync_q;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            div_q       <= div_d;
            db_q        <= db_d;
            pat_q       <= pat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign cols_o      = 4'b0001 << col_idx_q;
    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign scanning_o  = (state_q == ST_SCAN);
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed scenarios plus random row activity,
// every cycle compared against a behavioural model of the scanner rules.
module tb_keypad_scan_ctrl;
    localparam int SD = 4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] rows_i = 4'b0000;
    logic [3:0] cols_o, key_code_o;
    logic       key_valid_o, scanning_o;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .rows_i(rows_i), .cols_o(cols_o),
        .key_code_o(key_code_o), .key_valid_o(key_valid_o), .scanning_o(scanning_o)
    );

    always #5 clk = ~clk;

    typedef enum int {M_SCAN, M_PDB, M_HELD, M_RDB} mode_t;
    mode_t m_mode;
    int m_col, m_div, m_cnt, m_pat, m_code, m_valid;
    int seen_rows[2];  // [0] = first flop, [1] = what decisions see
    int n_cmp = 0, n_bad = 0, n_kv = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_SCAN; m_col = 0; m_div = 0; m_cnt = 0; m_pat = 0;
        m_code = 0; m_valid = 0; seen_rows[0] = 0; seen_rows[1] = 0;
    endtask

    function automatic int lowest_row(input int p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return 0;
    endfunction

    // One clock edge of the scanner rules, using the rows value seen two edges late.
    task automatic model_edge(input int r);
        int rs;
        rs = seen_rows[1];
        m_valid = 0;
        case (m_mode)
            M_SCAN:
                if (m_div >= 2 && rs != 0) begin
                    m_pat = rs; m_cnt = 0; m_mode = M_PDB;
                end else if (m_div == SD - 1) begin
                    m_div = 0; m_col = (m_col + 1) % 4;
                end else m_div++;
            M_PDB:
                if (rs == 0) begin
                    m_mode = M_SCAN; m_div = 0;
                end else if (rs != m_pat) begin
                    m_pat = rs; m_cnt = 0;
                end else if (m_cnt == DB - 1) begin
                    m_code = lowest_row(m_pat) * 4 + m_col; m_valid = 1; m_mode = M_HELD;
                end else m_cnt++;
            M_HELD:
                if (rs == 0) begin m_cnt = 0; m_mode = M_RDB; end
            M_RDB:
                if (rs != 0) m_cnt = 0;
                else if (m_cnt == DB - 1) begin
                    m_mode = M_SCAN; m_div = 0; m_col = (m_col + 1) % 4;
                end else m_cnt++;
        endcase
        seen_rows[1] = seen_rows[0];
        seen_rows[0] = r;
    endtask

    task automatic tick(input logic [3:0] r);
        rows_i = r;
        @(posedge clk);
        if (!rst_ni) model_reset(); else model_edge(int'(r));
        #1;
        chk("cols", cols_o, 32'(1 << m_col));
        chk("scanning", scanning_o, (m_mode == M_SCAN) ? 1 : 0);
        chk("key_valid", key_valid_o, m_valid);
        chk("key_code", key_code_o, m_code);
        if (key_valid_o === 1'b1) n_kv++;
    endtask

    task automatic wait_col(input int c);
        int n = 0;
        while (!(m_mode == M_SCAN && m_col == c && m_div == 0) && n < 40) begin
            tick(4'b0000); n++;
        end
        chk("wait_col", cols_o, 32'(1 << c));
    endtask

    task automatic release_keys(input int n);
        for (int i = 0; i < n; i++) tick(4'b0000);
    endtask

    initial begin
        logic seen_rise, prev_scan;
        logic [3:0] pat;
        int hold;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cols", cols_o, 4'b0001);
        chk("rst_scanning", scanning_o, 1);
        chk("rst_key_valid", key_valid_o, 0);
        chk("rst_key_code", key_code_o, 0);
        @(negedge clk) rst_ni = 1'b1;

        n_kv = 0;
        release_keys(20);
        chk("idle_pulses", n_kv, 0);
        $display("[tb] idle rotation: pulses=%0d", n_kv);

        wait_col(2);
        n_kv = 0;
        for (int i = 0; i < 70; i++) tick(4'b0100);
        chk("press_pulses", n_kv, 1);
        chk("press_code", key_code_o, 4'hA);
        chk("press_frozen", cols_o, 4'b0100);
        $display("[tb] clean press: key_code=%h pulses=%0d", key_code_o, n_kv);

        n_kv = 0; seen_rise = 1'b0; prev_scan = scanning_o;
        for (int i = 0; i < 26; i++) begin
            tick((i >= 4 && i < 6) ? 4'b0100 : 4'b0000);
            if (scanning_o && !prev_scan && !seen_rise) begin
                seen_rise = 1'b1;
                chk("release_col", cols_o, 4'b1000);
            end
            prev_scan = scanning_o;
        end
        chk("release_seen", seen_rise, 1);
        chk("release_pulses", n_kv, 0);
        $display("[tb] release debounce: resumed=%0d cols=%b", seen_rise, cols_o);

        n_kv = 0;
        for (int i = 0; i < 30; i++) tick(((i / 3) % 2 == 0) ? 4'b0100 : 4'b0000);
        chk("bounce_pulses", n_kv, 0);
        for (int i = 0; i < 20; i++) tick(4'b0100);
        chk("bounce_stable_pulses", n_kv, 1);
        $display("[tb] bouncy press: key_code=%h pulses=%0d", key_code_o, n_kv);
        release_keys(20);

        wait_col(0);
        for (int i = 0; i < 20; i++) tick(4'b1010);
        chk("two_rows_code", key_code_o, 4'h4);
        $display("[tb] two rows: key_code=%h", key_code_o);
        release_keys(20);

        wait_col(1);
        hold = 0;
        while (!(m_mode == M_PDB && m_cnt == 5) && hold < 30) begin
            tick(4'b0001); hold++;
        end
        chk("reach_db5", scanning_o, 0);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_cols", cols_o, 4'b0001);
        chk("async_key_valid", key_valid_o, 0);
        chk("async_key_code", key_code_o, 0);
        chk("async_scanning", scanning_o, 1);
        model_reset();
        tick(4'b0000);
        tick(4'b0000);
        @(negedge clk) rst_ni = 1'b1;
        n_kv = 0;
        release_keys(20);
        chk("post_rst_pulses", n_kv, 0);
        chk("post_rst_code", key_code_o, 0);
        $display("[tb] reset mid-debounce: cols=%b key_code=%h", cols_o, key_code_o);

        for (int t = 0; t < 60; t++) begin
            pat  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            hold = $urandom_range(1, 25);
            for (int i = 0; i < hold; i++) tick(pat);
        end
        release_keys(20);
        $display("[tb] random phase done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
